stim_sequencer: RTL

Upstream control stage that drives the `en`/`sel`/`d` inputs of the case-mux/flop stage. On a `start` pulse it walks `sel` through a fixed number of steps and drives `d` from an 8-bit LFSR. It holds each step stable for a programmable number of cycles and pulses `en` once per step so the downstream register captures exactly one sample. It reports `busy` and a one-cycle `done`, and supports abort and seed loading.

---
 rtl/stim_pkg.sv | 25 ++
 rtl/stim_lfsr.sv | 29 ++
 rtl/stim_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/stim_pkg.sv
// Shared types and LFSR helpers for the stimulus sequencer.
package stim_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD,
      S_DONE
   } stim_state_e;

   // Feedback taps on bits 7,5,4,3 (x^8+x^6+x^5+x^4+1)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [7:0] seed_fix(
      input logic [7:0] s,
      input logic [7:0] dflt
   );
      return (s == 8'h00) ? dflt : s;
   endfunction

endpackage

// File: rtl/stim_lfsr.sv
// 8-bit Fibonacci LFSR with seed load and single-step advance.
module stim_lfsr
   import stim_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       adv,
   output logic       lsb
);

   logic [7:0] q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= SEED;
      end else if (load) begin
         q <= seed_fix(seed, SEED);
      end else if (adv) begin
         q <= lfsr_next(q);
      end
   end

   assign lsb = q[0];

endmodule

// File: rtl/stim_sequencer.sv
// Walks sel through NUM_STEPS steps, holding each and pulsing en once.
module stim_sequencer
   import stim_pkg::*;
#(
   parameter int         NUM_STEPS   = 8,
   parameter int         HOLD_CYCLES = 2,
   parameter logic [7:0] LFSR_SEED   = 8'hA5,
   localparam int SW = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1,
   localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          seed_load,
   input  logic [7:0]    seed,
   output logic          en,
   output logic [1:0]    sel,
   output logic          d,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] step_idx
);

   localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
   localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD_CYCLES - 1);

   stim_state_e   state_q, state_n;
   logic [SW-1:0] step_q, step_n;
   logic [HW-1:0] hold_q, hold_n;
   logic [1:0]    sel_q, sel_n;
   logic          d_q, d_n;
   logic          lfsr_ld, lfsr_adv, lfsr_lsb;

   stim_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_ld),
      .seed  (seed),
      .adv   (lfsr_adv),
      .lsb   (lfsr_lsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         hold_q  <= '0;
         sel_q   <= '0;
         d_q     <= 1'b0;
      end else begin
         state_q <= state_n;
         step_q  <= step_n;
         hold_q  <= hold_n;
         sel_q   <= sel_n;
         d_q     <= d_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      step_n   = step_q;
      hold_n   = hold_q;
      sel_n    = sel_q;
      d_n      = d_q;
      lfsr_ld  = 1'b0;
      lfsr_adv = 1'b0;
      if (abort && state_q != S_IDLE) begin
         state_n = S_IDLE;
         sel_n   = '0;
         d_n     = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               lfsr_ld = seed_load;
               if (start) begin
                  state_n = S_RUN;
                  step_n  = '0;
                  hold_n  = '0;
               end
            end
            S_RUN: begin
               state_n = S_HOLD;
               hold_n  = '0;
               sel_n   = 2'(step_q);
               d_n     = lfsr_lsb;
            end
            S_HOLD: begin
               if (hold_q == LAST_HOLD) begin
                  lfsr_adv = 1'b1;
                  if (step_q == LAST_STEP) begin
                     state_n = S_DONE;
                  end else begin
                     step_n  = step_q + SW'(1);
                     state_n = S_RUN;
                  end
               end else begin
                  hold_n = hold_q + HW'(1);
               end
            end
            S_DONE: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   // Status outputs decode registered state only
   assign busy     = (state_q == S_RUN) || (state_q == S_HOLD);
   assign done     = (state_q == S_DONE);
   assign en       = (state_q == S_HOLD) && (hold_q == LAST_HOLD);
   assign sel      = sel_q;
   assign d        = d_q;
   assign step_idx = step_q;

endmodule
